// File: rtl/ifc_pkg.sv
// Shared types and default widths for the method-port command sequencer.
// Command records are packed so they can be stored directly in the queue memory.
package ifc_pkg;

    localparam int IFC_ADDR_W = 3;
    localparam int IFC_DATA_W = 1;

    typedef struct packed {
        logic                  write;
        logic [IFC_ADDR_W-1:0] addr;
        logic [IFC_DATA_W-1:0] data;
    } ifc_cmd_t;

    function automatic ifc_cmd_t ifc_cmd_make(
        input logic                  write,
        input logic [IFC_ADDR_W-1:0] addr,
        input logic [IFC_DATA_W-1:0] data
    );
        ifc_cmd_t c;
        c.write = write;
        c.addr  = addr;
        // Reads carry no payload; keep the stored data clean.
        c.data  = write ? data : '0;
        return c;
    endfunction

endpackage

// File: rtl/ifc_cmd_fifo.sv
// In-order command queue: DEPTH entries (power of two), head visible combinationally.
// Push is refused when full, even if a pop happens in the same cycle.
module ifc_cmd_fifo
    import ifc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  ifc_cmd_t push_cmd_i,
    input  logic     pop_i,
    output ifc_cmd_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];

    ifc_cmd_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked entirely by count_q.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_cmd_i;
        end
    end

endmodule

// File: rtl/ifc_cmd_master.sv
// Issues queued write/read commands to a method-port DUT when its *_rdy allows,
// returning read results through a single-entry valid/ready response register.
module ifc_cmd_master
    import ifc_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = IFC_ADDR_W,
    parameter int DATA_W = IFC_DATA_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data,
    output logic              write_en,
    input  logic              write_rdy,
    output logic [ADDR_W-1:0] read_address,
    output logic              read_en,
    input  logic [DATA_W-1:0] read_data,
    input  logic              read_rdy,
    output logic              busy
);

    ifc_cmd_t          head;
    logic              q_full;
    logic              q_empty;
    logic              push;
    logic              pop;
    logic              head_is_wr;
    logic              head_is_rd;
    logic              rsp_free;

    logic              rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0] rsp_addr_q,  rsp_addr_d;
    logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;

    assign cmd_ready = !q_full;
    assign push      = cmd_valid && !q_full;

    ifc_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (CLK),
        .rst_i      (RST),
        .push_i     (push),
        .push_cmd_i (ifc_cmd_make(cmd_write, cmd_addr, cmd_data)),
        .pop_i      (pop),
        .head_o     (head),
        .full_o     (q_full),
        .empty_o    (q_empty)
    );

    assign head_is_wr = !q_empty && head.write;
    assign head_is_rd = !q_empty && !head.write;
    // A read may issue only if its result has somewhere to land this cycle.
    assign rsp_free   = !rsp_valid_q || rsp_ready;

    always_comb begin
        write_en      = head_is_wr && write_rdy;
        read_en       = head_is_rd && read_rdy && rsp_free;
        write_address = '0;
        write_data    = '0;
        read_address  = '0;
        if (head_is_wr) begin
            write_address = head.addr;
            write_data    = head.data;
        end
        if (head_is_rd) begin
            read_address = head.addr;
        end
        pop = write_en || read_en;
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_data_d  = rsp_data_q;
        if (read_en) begin
            rsp_valid_d = 1'b1;
            rsp_addr_d  = head.addr;
            rsp_data_d  = read_data;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = !q_empty || rsp_valid_q;

endmodule

// File: tb/tb_ifc_cmd_master.sv
// Directed plus randomized bench for ifc_cmd_master against a queue-based reference model.
module tb_ifc_cmd_master;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 1;

    logic              CLK = 1'b0;
    logic              RST;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid, rsp_ready;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] write_address, read_address;
    logic [DATA_W-1:0] write_data, read_data;
    logic              write_en, write_rdy, read_en, read_rdy, busy;

    ifc_cmd_master #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .write_address(write_address), .write_data(write_data), .write_en(write_en),
        .write_rdy(write_rdy),
        .read_address(read_address), .read_en(read_en), .read_data(read_data),
        .read_rdy(read_rdy), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic              w;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } mcmd_t;

    mcmd_t             mq[$];
    logic              mv;
    logic [ADDR_W-1:0] ma;
    logic [DATA_W-1:0] md;
    bit                known = 1'b0;
    logic              e_we, e_re;
    int                vectors = 0;
    int                miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_model();
        bit    emp;
        mcmd_t h;
        emp = (mq.size() == 0);
        h   = '{w: 1'b0, a: '0, d: '0};
        if (!emp) h = mq[0];
        e_we = !emp && h.w && write_rdy;
        e_re = !emp && !h.w && read_rdy && (!mv || rsp_ready);
        chk("cmd_ready", cmd_ready, mq.size() != DEPTH);
        chk("write_en",  write_en,  e_we);
        chk("read_en",   read_en,   e_re);
        chk("write_address", write_address, (!emp && h.w) ? h.a : '0);
        chk("write_data",    write_data,    (!emp && h.w) ? h.d : '0);
        chk("read_address",  read_address,  (!emp && !h.w) ? h.a : '0);
        chk("rsp_valid", rsp_valid, mv);
        chk("rsp_addr",  rsp_addr,  ma);
        chk("rsp_data",  rsp_data,  md);
        chk("busy",      busy,      !emp || mv);
    endtask

    task automatic update_model();
        mcmd_t h;
        bit    was_full;
        if (RST) begin
            mq.delete();
            mv = 1'b0; ma = '0; md = '0;
            known = 1'b1;
        end else if (known) begin
            was_full = (mq.size() == DEPTH);
            if (e_we || e_re) begin
                h = mq.pop_front();
                if (e_re) begin
                    mv = 1'b1; ma = h.a; md = read_data;
                end
            end
            if (!e_re && rsp_ready) mv = 1'b0;
            if (cmd_valid && !was_full)
                mq.push_back('{w: cmd_write, a: cmd_addr, d: cmd_write ? cmd_data : '0});
        end
    endtask

    // One clock: check outputs mid-cycle, advance model at the edge, return 1 unit after it.
    task automatic cycle();
        @(negedge CLK);
        if (known) compare_model();
        @(posedge CLK);
        update_model();
        #1;
    endtask

    task automatic offer(input logic w, input int a, input int d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a[ADDR_W-1:0];
        cmd_data  = d[DATA_W-1:0];
    endtask

    initial begin
        RST = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0;
        rsp_ready = 1'b0; write_rdy = 1'b0; read_rdy = 1'b0; read_data = '0;
        cycle(); cycle();
        RST = 1'b0;
        #1;
        chk("rst cmd_ready", cmd_ready, 1);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst write_en", write_en, 0);
        chk("rst read_en", read_en, 0);
        chk("rst busy", busy, 0);

        // single write
        write_rdy = 1'b1;
        offer(1'b1, 4, 1);
        cycle();
        cmd_valid = 1'b0;
        #1;
        chk("w1 write_en", write_en, 1);
        chk("w1 write_address", write_address, 4);
        chk("w1 write_data", write_data, 1);
        cycle();
        #1;
        chk("w1 busy after", busy, 0);

        // write stall and full
        write_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            offer(1'b1, i, i % 2);
            cycle();
        end
        cmd_valid = 1'b0;
        #1;
        chk("full cmd_ready", cmd_ready, 0);
        chk("full write_en", write_en, 0);
        write_rdy = 1'b1;
        #1;
        chk("drain0 write_en", write_en, 1);
        chk("drain0 write_address", write_address, 0);
        chk("drain0 cmd_ready", cmd_ready, 0);
        cycle();
        #1;
        chk("drain1 cmd_ready", cmd_ready, 1);
        chk("drain1 write_address", write_address, 1);
        for (int i = 0; i < 3; i++) cycle();

        // single read with held response
        read_rdy = 1'b1; read_data = 1'b1; rsp_ready = 1'b0;
        offer(1'b0, 3, 0);
        cycle();
        cmd_valid = 1'b0;
        #1;
        chk("r1 read_en", read_en, 1);
        chk("r1 read_address", read_address, 3);
        cycle();
        #1;
        chk("r1 rsp_valid", rsp_valid, 1);
        chk("r1 rsp_addr", rsp_addr, 3);
        chk("r1 rsp_data", rsp_data, 1);
        cycle(); cycle();
        #1;
        chk("r1 rsp held", rsp_valid, 1);
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
        #1;
        chk("r1 rsp taken", rsp_valid, 0);

        // response backpressure
        read_data = 1'b0;
        offer(1'b0, 0, 0);
        cycle();
        offer(1'b0, 1, 0);
        cycle();
        cmd_valid = 1'b0;
        #1;
        chk("bp read_en withheld", read_en, 0);
        chk("bp rsp_addr", rsp_addr, 0);
        read_data = 1'b1; rsp_ready = 1'b1;
        #1;
        chk("bp read_en pulse", read_en, 1);
        chk("bp read_address", read_address, 1);
        cycle();
        rsp_ready = 1'b0;
        #1;
        chk("bp rsp_valid", rsp_valid, 1);
        chk("bp rsp_addr 2nd", rsp_addr, 1);
        chk("bp rsp_data 2nd", rsp_data, 1);
        rsp_ready = 1'b1;
        cycle();

        // ordered mix, then reset with commands queued
        write_rdy = 1'b1; read_rdy = 1'b1;
        offer(1'b1, 4, 1); cycle();
        offer(1'b1, 5, 0); cycle();
        offer(1'b0, 3, 0); cycle();
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        write_rdy = 1'b0; read_rdy = 1'b0;
        offer(1'b1, 2, 1); cycle();
        offer(1'b0, 6, 0); cycle();
        offer(1'b1, 7, 1); cycle();
        cmd_valid = 1'b0;
        #1;
        chk("pre-rst busy", busy, 1);
        RST = 1'b1;
        cycle();
        RST = 1'b0; write_rdy = 1'b1; read_rdy = 1'b1;
        #1;
        chk("post-rst busy", busy, 0);
        chk("post-rst write_en", write_en, 0);
        chk("post-rst read_en", read_en, 0);
        chk("post-rst cmd_ready", cmd_ready, 1);
        cycle(); cycle();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            RST       = ($urandom_range(0, 79) == 0);
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_write = $urandom_range(0, 1);
            cmd_addr  = ADDR_W'($urandom);
            cmd_data  = DATA_W'($urandom);
            write_rdy = ($urandom_range(0, 3) != 0);
            read_rdy  = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            read_data = DATA_W'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
